// File: rtl/syn_fifo_param.sv
// Parameterized synchronous FIFO with registered status flags, sticky error flags
// and an optional first-word-fall-through output stage.
module syn_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  wr_acc, rd_acc;
    logic                  mem_we, mem_re, bypass;
    logic [LW-1:0]         level_nxt;

    assign wr_acc = wr_en && !full  && !clear;
    assign rd_acc = rd_en && !empty && !clear;

    generate
        if (FWFT != 0) begin : g_fwft
            // The output register holds the head word; the array holds the rest.
            // A write that would land in an empty array with a free (or freeing)
            // output stage goes straight to the output register.
            logic ram_empty;
            assign ram_empty = (level <= LW'(1));
            assign bypass    = wr_acc && ram_empty && (empty || rd_acc);
            assign mem_we    = wr_acc && !bypass;
            assign mem_re    = rd_acc && !ram_empty;
        end else begin : g_std
            assign bypass = 1'b0;
            assign mem_we = wr_acc;
            assign mem_re = rd_acc;
        end
    endgenerate

    always_comb begin
        level_nxt = level;
        if (wr_acc && !rd_acc)
            level_nxt = level + LW'(1);
        else if (rd_acc && !wr_acc)
            level_nxt = level - LW'(1);
    end

    // Storage: no reset, synchronous write; read is registered into data_out.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            data_valid   <= 1'b0;
            data_out     <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clear) begin
            // Memory contents and data_out are left as they are.
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            data_valid   <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (mem_we)
                wr_ptr <= wr_ptr + 1'b1;
            if (mem_re)
                rd_ptr <= rd_ptr + 1'b1;
            level        <= level_nxt;
            full         <= (level_nxt == DEPTH_L);
            empty        <= (level_nxt == '0);
            almost_full  <= (level_nxt >= AF_L);
            almost_empty <= (level_nxt <= AE_L);
            // Full/empty are the pre-edge values, so a write against a full
            // FIFO flags overflow even when a read frees a slot that cycle.
            overflow     <= overflow  | (wr_en & full);
            underflow    <= underflow | (rd_en & empty);
            if (FWFT != 0)
                data_valid <= (level_nxt != '0);
            else
                data_valid <= rd_acc;
            if (bypass)
                data_out <= data_in;
            else if (mem_re)
                data_out <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_syn_fifo_param.sv
// Randomized scoreboard bench: one standard-read and one FWFT instance share the
// same stimulus and are checked against a queue-based reference model.
module tb_syn_fifo_param;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] d0, d1;
    logic          dv0, dv1, f0, f1, e0, e1, af0, af1, ae0, ae1, ov0, ov1, un0, un1;
    logic [AW:0]   l0, l1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    syn_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(4)) u_std (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(d0), .data_valid(dv0), .full(f0), .empty(e0), .almost_full(af0),
        .almost_empty(ae0), .level(l0), .overflow(ov0), .underflow(un0));

    syn_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(4)) u_fw (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(d1), .data_valid(dv1), .full(f1), .empty(e1), .almost_full(af1),
        .almost_empty(ae1), .level(l1), .overflow(ov1), .underflow(un1));

    // Reference model: contents as a queue, flags from occupancy arithmetic.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp0[$];
    bit m_ovf = 0, m_unf = 0, exp_v0 = 0;
    bit m_wa, m_ra;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete(); exp0.delete();
            m_ovf = 0; m_unf = 0; exp_v0 = 0;
        end else if (clear) begin
            q.delete();
            m_ovf = 0; m_unf = 0; exp_v0 = 0;
        end else begin
            m_wa = wr_en && (q.size() < DEPTH);
            m_ra = rd_en && (q.size() > 0);
            if (wr_en && q.size() == DEPTH) m_ovf = 1;
            if (rd_en && q.size() == 0) m_unf = 1;
            exp_v0 = m_ra;
            if (m_ra) exp0.push_back(q.pop_front());
            if (m_wa) q.push_back(data_in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag, input logic [AW:0] lv, input logic f, input logic e,
                              input logic af, input logic ae, input logic ov, input logic un);
        int sz;
        sz = q.size();
        chk({tag, ".level"}, 32'(lv), 32'(sz));
        chk({tag, ".full"}, 32'(f), 32'(sz == DEPTH));
        chk({tag, ".empty"}, 32'(e), 32'(sz == 0));
        chk({tag, ".almost_full"}, 32'(af), 32'(sz >= 12));
        chk({tag, ".almost_empty"}, 32'(ae), 32'(sz <= 4));
        chk({tag, ".overflow"}, 32'(ov), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(un), 32'(m_unf));
    endtask

    // Monitor: compares everything the DUTs present, away from the rising edge.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        chk_status("std", l0, f0, e0, af0, ae0, ov0, un0);
        chk_status("fwft", l1, f1, e1, af1, ae1, ov1, un1);
        chk("std.data_valid", 32'(dv0), 32'(exp_v0));
        if (dv0) begin
            if (exp0.size() == 0) begin
                chk("std.unexpected_read", 32'(d0), 32'hFFFF_FFFF);
            end else begin
                e = exp0.pop_front();
                chk("std.data_out", 32'(d0), 32'(e));
            end
        end else begin
            exp0.delete();
        end
        chk("fwft.data_valid", 32'(dv1), 32'(q.size() > 0));
        if (q.size() > 0)
            chk("fwft.data_out", 32'(d1), 32'(q[0]));
    end

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wr_en = w; data_in = d; rd_en = r; clear = c;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst.std.data_out", 32'(d0), 0);
        chk("rst.fwft.data_out", 32'(d1), 0);
        chk("rst.std.data_valid", 32'(dv0), 0);
        chk("rst.fwft.data_valid", 32'(dv1), 0);
        chk("rst.std.level", 32'(l0), 0);
        chk("rst.fwft.level", 32'(l1), 0);
        chk("rst.empty", 32'({e0, e1, ae0, ae1}), 32'hF);
        chk("rst.full", 32'({f0, f1, af0, af1}), 0);
        chk("rst.errflags", 32'({ov0, ov1, un0, un1}), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Fill to full, overflow attempt, then drain in order.
        for (int i = 1; i <= 16; i++) cyc(1, DW'(i), 0, 0);
        cyc(1, 16'hBEEF, 0, 0);
        cyc(1, 16'hBEEF, 1, 0);
        for (int i = 0; i < 18; i++) cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);

        // Underflow on empty, then clear.
        cyc(0, '0, 0, 1);
        cyc(0, '0, 1, 0);
        cyc(1, 16'h0042, 1, 0);
        cyc(0, '0, 0, 1);
        cyc(0, '0, 0, 0);

        // FWFT single word presentation and pop.
        cyc(1, 16'h1234, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);

        // Steady level 8 with simultaneous read/write, wrapping the pointers.
        for (int i = 0; i < 8; i++) cyc(1, 16'($urandom), 0, 0);
        for (int i = 0; i < 40; i++) cyc(1, 16'($urandom), 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 16'($urandom), 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, '0, 1, 0);

        // Random traffic, biased toward full, then toward empty, then balanced.
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 99) < 80, 16'($urandom), $urandom_range(0, 99) < 30, 0);
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 99) < 20, 16'($urandom), $urandom_range(0, 99) < 80, 0);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 50,
                $urandom_range(0, 99) == 0);

        // Asynchronous reset in the middle of a burst at level 9.
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, 16'($urandom), 0, 0);
        wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h7777;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 16'hA5A5, 0, 0);
        cyc(1, 16'h5A5A, 0, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
